// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Sweeps an N_VARS-bit input vector through every combination. Each vector
//   is held for SETTLE+1 cycles. On the last cycle of each hold it samples two
//   implementations of the same boolean function: a reference and a
//   simplified one. It builds the reference truth table and counts its
//   minterms, and it records equivalence statistics between the two.
//
// Ports
//   clk                 single clock, rising edge
//   rst_n               asynchronous active-low reset
//   start               begin a sweep (accepted only when idle, abort wins)
//   abort               terminate a running sweep, results held
//   fn_ref              reference function output for the applied vec
//   fn_dut              simplified function output for the applied vec
//   vec                 applied input vector (MSB = variable a)
//   busy                high from start acceptance until sweep exit
//   done                one-cycle pulse at sweep completion
//   truth_table         bit i = fn_ref sampled with vec == i
//   minterm_count       number of ones in truth_table
//   mismatch            sticky, any sampled vector where fn_ref != fn_dut
//   mismatch_count      number of differing vectors
//   first_mismatch_idx  lowest differing vector, 0 if none
module truth_table_sweeper #(
  parameter int unsigned N_VARS = 5,
  parameter int unsigned SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   fn_ref,
  input  logic                   fn_dut,
  output logic [N_VARS-1:0]      vec,
  output logic                   busy,
  output logic                   done,
  output logic [2**N_VARS-1:0]   truth_table,
  output logic [N_VARS:0]        minterm_count,
  output logic                   mismatch,
  output logic [N_VARS:0]        mismatch_count,
  output logic [N_VARS-1:0]      first_mismatch_idx
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t     state, state_nx;
  logic [3:0] settle_cnt;
  logic       accept;
  logic       last_vec;
  logic       differ;

  assign accept   = (state == S_IDLE) && start && !abort;
  assign last_vec = (vec == '1);
  assign differ   = fn_ref ^ fn_dut;

  // busy and done are pure state decodes, so reset clears them immediately
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (accept) state_nx = S_SETTLE;
      S_SETTLE: begin
        if (abort)                           state_nx = S_IDLE;
        else if (settle_cnt == SETTLE_LAST)  state_nx = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (abort)         state_nx = S_IDLE;
        else if (last_vec) state_nx = S_DONE;
        else               state_nx = S_SETTLE;
      end
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec                <= '0;
      settle_cnt         <= '0;
      truth_table        <= '0;
      minterm_count      <= '0;
      mismatch           <= 1'b0;
      mismatch_count     <= '0;
      first_mismatch_idx <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            vec                <= '0;
            settle_cnt         <= '0;
            truth_table        <= '0;
            minterm_count      <= '0;
            mismatch           <= 1'b0;
            mismatch_count     <= '0;
            first_mismatch_idx <= '0;
          end
        end
        S_SETTLE: begin
          if (!abort) settle_cnt <= settle_cnt + 4'd1;
        end
        S_SAMPLE: begin
          // an abort landing on the sample cycle discards that vector
          if (!abort) begin
            truth_table[vec] <= fn_ref;
            minterm_count    <= minterm_count + (N_VARS+1)'(fn_ref);
            if (differ) begin
              mismatch_count <= mismatch_count + (N_VARS+1)'(1);
              mismatch       <= 1'b1;
              if (!mismatch) first_mismatch_idx <= vec;
            end
            if (!last_vec) begin
              vec        <= vec + N_VARS'(1);
              settle_cnt <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // DUT with SETTLE=1
  logic        start1 = 1'b0, abort1 = 1'b0;
  logic        fn_ref1, fn_dut1;
  logic [4:0]  vec1, first1;
  logic        busy1, done1, mm1;
  logic [31:0] tt1;
  logic [5:0]  min1, cnt1;

  // DUT with SETTLE=3
  logic        start3 = 1'b0, abort3 = 1'b0;
  logic        fn_ref3, fn_dut3;
  logic [4:0]  vec3, first3;
  logic        busy3, done3, mm3;
  logic [31:0] tt3;
  logic [5:0]  min3, cnt3;

  // function stimulus: truth tables indexed by the applied vector
  logic [31:0] tab1 = '0, msk1 = '0, tab3 = '0;
  logic [3:0]  pipe;
  logic        dly4 = 1'b0;

  assign fn_ref1 = tab1[vec1];
  assign fn_dut1 = tab1[vec1] ^ msk1[vec1];
  assign fn_ref3 = tab3[vec3];
  assign fn_dut3 = dly4 ? pipe[3] : pipe[2];

  always @(posedge clk) pipe <= {pipe[2:0], fn_ref3};

  always #5 clk = ~clk;

  truth_table_sweeper #(.N_VARS(5), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .fn_ref(fn_ref1), .fn_dut(fn_dut1), .vec(vec1), .busy(busy1),
    .done(done1), .truth_table(tt1), .minterm_count(min1),
    .mismatch(mm1), .mismatch_count(cnt1), .first_mismatch_idx(first1)
  );

  truth_table_sweeper #(.N_VARS(5), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
    .fn_ref(fn_ref3), .fn_dut(fn_dut3), .vec(vec3), .busy(busy3),
    .done(done3), .truth_table(tt3), .minterm_count(min3),
    .mismatch(mm3), .mismatch_count(cnt3), .first_mismatch_idx(first3)
  );

  // view of the currently selected DUT
  logic        sel = 1'b0;
  logic [4:0]  cur_vec, cur_first;
  logic        cur_busy, cur_done, cur_mm;
  logic [31:0] cur_tt;
  logic [5:0]  cur_min, cur_cnt;

  always_comb begin
    cur_vec   = sel ? vec3   : vec1;
    cur_first = sel ? first3 : first1;
    cur_busy  = sel ? busy3  : busy1;
    cur_done  = sel ? done3  : done1;
    cur_mm    = sel ? mm3    : mm1;
    cur_tt    = sel ? tt3    : tt1;
    cur_min   = sel ? min3   : min1;
    cur_cnt   = sel ? cnt3   : cnt1;
  end

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_tt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_start(input logic v);
    if (sel) start3 = v; else start1 = v;
  endtask

  task automatic drive_abort(input logic v);
    if (sel) abort3 = v; else abort1 = v;
  endtask

  // Reference: results after the first n vectors of table t have been captured,
  // where m marks the vectors on which the two functions disagree.
  task automatic model(input logic [31:0] t, input logic [31:0] m, input int n,
                       output logic [31:0] e_tt, output int e_min, output int e_mm,
                       output int e_cnt, output int e_first);
    e_tt = '0; e_min = 0; e_cnt = 0; e_first = 0;
    for (int i = 0; i < n; i++) begin
      e_tt[i] = t[i];
      e_min += int'(t[i]);
      if (m[i]) begin
        if (e_cnt == 0) e_first = i;
        e_cnt++;
      end
    end
    e_mm = (e_cnt != 0) ? 1 : 0;
  endtask

  task automatic check_results(input logic [31:0] t, input logic [31:0] m, input int n);
    logic [31:0] e_tt;
    int e_min, e_mm, e_cnt, e_first;
    model(t, m, n, e_tt, e_min, e_mm, e_cnt, e_first);
    check("truth_table", cur_tt, e_tt);
    check("minterm_count", cur_min, e_min);
    check("mismatch", cur_mm, e_mm);
    check("mismatch_count", cur_cnt, e_cnt);
    check("first_mismatch_idx", cur_first, e_first);
    last_tt = e_tt;
  endtask

  // One sweep on the selected DUT. stop_at < 32 aborts in the first cycle of
  // that vector; poke_at >= 0 pulses start in the first cycle of that vector.
  task automatic run_sweep(input int s, input logic [31:0] t, input logic [31:0] m,
                           input int stop_at, input int poke_at);
    int cnt, ndone, hold;
    hold = s + 1;
    @(negedge clk); drive_start(1'b1);
    @(negedge clk); drive_start(1'b0);
    check("busy_on_start", cur_busy, 1);
    cnt = 0; ndone = 0;
    while (cnt <= 34 * hold) begin
      if (cnt < 32 * hold && cnt / hold <= stop_at)
        check("vec_hold", cur_vec, cnt / hold);
      if (poke_at >= 0 && cnt == poke_at * hold) drive_start(1'b1);
      if (stop_at < 32 && cnt == stop_at * hold) begin
        drive_abort(1'b1);
        @(negedge clk); drive_abort(1'b0);
        check("abort_busy", cur_busy, 0);
        break;
      end
      if (cur_done) begin ndone++; break; end
      @(negedge clk); cnt++;
      drive_start(1'b0);
    end
    if (stop_at >= 32) begin
      check("done_latency", cnt, 32 * hold);
      check("vec_at_done", cur_vec, 31);
      check("busy_at_done", cur_busy, 1);
      @(negedge clk);
      check("done_pulse_width", cur_done, 0);
      check("busy_after_done", cur_busy, 0);
      check("vec_after_done", cur_vec, 31);
      check_results(t, m, 32);
    end else begin
      repeat (2 * hold + 4) begin
        @(negedge clk);
        if (cur_done) ndone++;
        check("abort_stays_idle", cur_busy, 0);
      end
      check("abort_no_done", ndone, 0);
      check_results(t, m, stop_at);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_vec"}, cur_vec, 0);
    check({tag, "_busy"}, cur_busy, 0);
    check({tag, "_done"}, cur_done, 0);
    check({tag, "_tt"}, cur_tt, 0);
    check({tag, "_min"}, cur_min, 0);
    check({tag, "_mm"}, cur_mm, 0);
    check({tag, "_cnt"}, cur_cnt, 0);
    check({tag, "_first"}, cur_first, 0);
  endtask

  initial begin
    logic [31:0] t, m;
    int waited;

    // reset state of both DUTs
    #12;
    sel = 1'b0; #1; check_zero("reset1");
    sel = 1'b1; #1; check_zero("reset3");
    @(negedge clk); rst_n = 1'b1;
    sel = 1'b0;

    // equal functions a&b
    for (int i = 0; i < 32; i++) t[i] = ((i >> 4) & (i >> 3) & 1) != 0;
    tab1 = t; msk1 = '0;
    run_sweep(1, t, '0, 32, -1);

    // single difference at 13, with an ignored start pulse at vector 5
    for (int i = 0; i < 32; i++) t[i] = (i % 2) == 1;
    m = 32'h0000_2000;
    tab1 = t; msk1 = m;
    run_sweep(1, t, m, 32, 5);

    // abort and start together while idle: nothing starts, results held
    @(negedge clk); start1 = 1'b1; abort1 = 1'b1;
    @(negedge clk); start1 = 1'b0; abort1 = 1'b0;
    repeat (4) begin
      check("idle_abort_start_busy", cur_busy, 0);
      @(negedge clk);
    end
    check("idle_hold_tt", cur_tt, last_tt);
    check("idle_hold_cnt", cur_cnt, 1);
    check("idle_hold_first", cur_first, 13);

    // multiple differences at 3, 7, 30
    t = $urandom(); m = 32'h4000_0088;
    tab1 = t; msk1 = m;
    run_sweep(1, t, m, 32, -1);

    // abort at vector 20
    t = $urandom(); m = $urandom() & $urandom();
    tab1 = t; msk1 = m;
    run_sweep(1, t, m, 20, -1);

    // asynchronous reset mid-sweep at vector 10
    t = $urandom(); m = $urandom() & $urandom() & $urandom();
    tab1 = t; msk1 = m;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    waited = 0;
    while (vec1 != 5'd10 && waited < 200) begin @(negedge clk); waited++; end
    check("reach_vec10", vec1, 10);
    #2; rst_n = 1'b0; #1;
    check_zero("midreset");
    @(negedge clk); rst_n = 1'b1;
    run_sweep(1, t, m, 32, -1);

    // random sweeps
    for (int r = 0; r < 3; r++) begin
      t = $urandom(); m = (r == 0) ? 32'h0 : ($urandom() & $urandom());
      tab1 = t; msk1 = m;
      run_sweep(1, t, m, 32, -1);
    end

    // settle timing on the SETTLE=3 instance: 3-cycle delayed copy must match
    sel = 1'b1;
    t = $urandom();
    t[1] = ~t[0];
    tab3 = t; dly4 = 1'b0;
    run_sweep(3, t, '0, 32, -1);

    // 4-cycle delay samples the previous vector's value (vec held 31 before)
    dly4 = 1'b1;
    m[0] = t[0] ^ t[31];
    for (int i = 1; i < 32; i++) m[i] = t[i] ^ t[i-1];
    run_sweep(3, t, m, 32, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
